// File: rtl/parity_word_framer.sv
// Serial parity framer: splits an LSB-first bit stream into DATA_BITS words and
// generates or checks one parity bit per word. Optional sticky error: PARITY_STICKY_ERR_EN.
module parity_word_framer #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             wr_en,
  input  logic             even_sel,
  input  logic             check_mode,
`ifdef PARITY_STICKY_ERR_EN
  input  logic             clr_err,
  output logic             err_sticky,
`endif
  output logic             parity_out,
  output logic             parity_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BCW = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;

  logic [1:0]     state;
  logic           acc;
  logic [BCW-1:0] bit_cnt;
  logic           even_l;
  logic           check_l;
  logic           exp_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      acc          <= 1'b0;
      bit_cnt      <= '0;
      even_l       <= 1'b0;
      check_l      <= 1'b0;
      exp_par      <= 1'b0;
      parity_out   <= 1'b0;
      parity_valid <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      word_cnt     <= '0;
    end else begin
      parity_valid <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en) begin
            acc     <= data_in;
            bit_cnt <= BCW'(1);
            even_l  <= even_sel;
            check_l <= check_mode;
            // Single-bit words complete on the very edge that starts them.
            if (DATA_BITS == 1) begin
              if (check_mode) begin
                exp_par <= data_in ^ even_sel;
                state   <= S_PAR;
              end else begin
                parity_out   <= data_in ^ even_sel;
                parity_valid <= 1'b1;
                word_cnt     <= word_cnt + CNT_W'(1);
              end
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (wr_en) begin
            acc     <= acc ^ data_in;
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(DATA_BITS - 1)) begin
              if (check_l) begin
                exp_par <= acc ^ data_in ^ even_l;
                state   <= S_PAR;
              end else begin
                parity_out   <= acc ^ data_in ^ even_l;
                parity_valid <= 1'b1;
                word_cnt     <= word_cnt + CNT_W'(1);
                state        <= S_IDLE;
              end
            end
          end else begin
            frame_err <= 1'b1;
            acc       <= 1'b0;
            bit_cnt   <= '0;
            state     <= S_IDLE;
          end
        end
        S_PAR: begin
          // An idle gap before the parity bit is legal; just keep waiting.
          if (wr_en) begin
            parity_out   <= exp_par;
            parity_valid <= 1'b1;
            parity_err   <= data_in ^ exp_par;
            word_cnt     <= word_cnt + CNT_W'(1);
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

`ifdef PARITY_STICKY_ERR_EN
  // Set has priority over clear so a new error is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_sticky <= 1'b0;
    else if (parity_err | frame_err) err_sticky <= 1'b1;
    else if (clr_err)                err_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_parity_word_framer.sv
// Bench for parity_word_framer: directed scenarios plus random traffic on an
// 8-bit/16-bit-count instance and a 1-bit/4-bit-count instance, against a word-level model.
module tb_parity_word_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic d0 = 0, w0 = 0, e0 = 0, c0 = 0;
  logic d1 = 0, w1 = 0, e1 = 0, c1 = 0;
  logic po0, pv0, pe0, fe0, bz0;
  logic po1, pv1, pe1, fe1, bz1;
  logic [15:0] wc0;
  logic [3:0]  wc1;
`ifdef PARITY_STICKY_ERR_EN
  logic clr0 = 0, clr1 = 0, st0, st1;
`endif

  parity_word_framer #(.DATA_BITS(8), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(d0), .wr_en(w0), .even_sel(e0), .check_mode(c0),
`ifdef PARITY_STICKY_ERR_EN
    .clr_err(clr0), .err_sticky(st0),
`endif
    .parity_out(po0), .parity_valid(pv0), .parity_err(pe0), .frame_err(fe0),
    .busy(bz0), .word_cnt(wc0));

  parity_word_framer #(.DATA_BITS(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(d1), .wr_en(w1), .even_sel(e1), .check_mode(c1),
`ifdef PARITY_STICKY_ERR_EN
    .clr_err(clr1), .err_sticky(st1),
`endif
    .parity_out(po1), .parity_valid(pv1), .parity_err(pe1), .frame_err(fe1),
    .busy(bz1), .word_cnt(wc1));

  int checks = 0;
  int errors = 0;
  bit rnd0 = 0, rnd1 = 0;

  // Word-level reference: collected bits, latched modes, pending parity slot.
  int          db[2]  = '{8, 1};
  int          cmask[2] = '{32'hFFFF, 32'hF};
  int          nb[2];
  logic [63:0] wd[2];
  bit          inp[2], expp[2], evl[2], ckl[2];
  int          cnt[2];
  bit          mo[2], mv[2], mpe[2], mfe[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; wd[i] = '0; inp[i] = 0; expp[i] = 0; evl[i] = 0; ckl[i] = 0;
      cnt[i] = 0; mo[i] = 0; mv[i] = 0; mpe[i] = 0; mfe[i] = 0;
    end
  endtask

  task automatic upd(input int i, input bit d, input bit w, input bit e, input bit c);
    bit p;
    mv[i] = 0; mpe[i] = 0; mfe[i] = 0;
    if (inp[i]) begin
      if (w) begin
        mo[i] = expp[i]; mv[i] = 1; mpe[i] = (d != expp[i]); cnt[i]++; inp[i] = 0;
      end
    end else if (nb[i] > 0) begin
      if (!w) begin
        mfe[i] = 1; nb[i] = 0; wd[i] = '0;
      end else begin
        wd[i][nb[i]] = d; nb[i]++;
      end
    end else if (w) begin
      evl[i] = e; ckl[i] = c; wd[i] = '0; wd[i][0] = d; nb[i] = 1;
    end
    if (nb[i] == db[i]) begin
      p = ($countones(wd[i]) % 2 == 1) ^ evl[i];
      if (ckl[i]) begin expp[i] = p; inp[i] = 1; end
      else begin mo[i] = p; mv[i] = 1; cnt[i]++; end
      nb[i] = 0; wd[i] = '0;
    end
  endtask

  task automatic compare_all();
    chk("u0_parity_out",   64'(po0), 64'(mo[0]));
    chk("u0_parity_valid", 64'(pv0), 64'(mv[0]));
    chk("u0_parity_err",   64'(pe0), 64'(mpe[0]));
    chk("u0_frame_err",    64'(fe0), 64'(mfe[0]));
    chk("u0_busy",         64'(bz0), 64'(inp[0] || nb[0] > 0));
    chk("u0_word_cnt",     64'(wc0), 64'(cnt[0] & cmask[0]));
    chk("u1_parity_out",   64'(po1), 64'(mo[1]));
    chk("u1_parity_valid", 64'(pv1), 64'(mv[1]));
    chk("u1_parity_err",   64'(pe1), 64'(mpe[1]));
    chk("u1_frame_err",    64'(fe1), 64'(mfe[1]));
    chk("u1_busy",         64'(bz1), 64'(inp[1] || nb[1] > 0));
    chk("u1_word_cnt",     64'(wc1), 64'(cnt[1] & cmask[1]));
  endtask

  task automatic cyc();
    if (rnd0) begin
      d0 = $urandom_range(0, 1); w0 = ($urandom_range(0, 7) != 0);
      e0 = $urandom_range(0, 1); c0 = $urandom_range(0, 1);
    end
    if (rnd1) begin
      d1 = $urandom_range(0, 1); w1 = ($urandom_range(0, 5) != 0);
      e1 = $urandom_range(0, 1); c1 = $urandom_range(0, 1);
    end
    @(posedge clk);
    #1;
    upd(0, d0, w0, e0, c0);
    upd(1, d1, w1, e1, c1);
    compare_all();
  endtask

  task automatic feed_word(input logic [63:0] val, input int n, input bit ev, input bit ck);
    logic [63:0] v;
    v = val;
    for (int b = 0; b < n; b++) begin
      d0 = v[b]; w0 = 1; e0 = ev; c0 = ck;
      cyc();
    end
  endtask

  task automatic idle0();
    w0 = 0; d0 = 0;
    cyc();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_u0_out"}, 64'({po0, pv0, pe0, fe0, bz0}), 64'(0));
    chk({tag, "_u0_cnt"}, 64'(wc0), 64'(0));
    chk({tag, "_u1_out"}, 64'({po1, pv1, pe1, fe1, bz1}), 64'(0));
    chk({tag, "_u1_cnt"}, 64'(wc1), 64'(0));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    // Single-bit instance: bits 1,0 then enough words to wrap the 4-bit count.
    w1 = 1; e1 = 0; c1 = 0; d1 = 1;
    cyc();
    chk("u1_bit1_par", 64'(po1), 64'(1));
    chk("u1_bit1_val", 64'(pv1), 64'(1));
    d1 = 0;
    cyc();
    chk("u1_bit0_par", 64'(po1), 64'(0));
    chk("u1_bit0_val", 64'(pv1), 64'(1));
    for (int k = 0; k < 14; k++) begin
      d1 = $urandom_range(0, 1);
      cyc();
    end
    chk("u1_wrap_cnt", 64'(wc1), 64'(0));
    rnd1 = 1;

    // Generate 8'h96 with even_sel=1.
    feed_word(64'h96, 8, 1, 0);
    chk("gen96_par", 64'(po0), 64'(1));
    chk("gen96_val", 64'(pv0), 64'(1));
    idle0();
    chk("gen96_val_drop", 64'(pv0), 64'(0));
    chk("gen96_cnt", 64'(wc0), 64'(1));
    chk("gen96_busy", 64'(bz0), 64'(0));

    // Back-to-back 8'h07, 8'h00, even_sel=0.
    feed_word(64'h07, 8, 0, 0);
    chk("b2b_first_par", 64'(po0), 64'(1));
    feed_word(64'h00, 8, 0, 0);
    chk("b2b_second_par", 64'(po0), 64'(0));
    chk("b2b_second_val", 64'(pv0), 64'(1));
    idle0();
    chk("b2b_cnt", 64'(wc0), 64'(3));

    // Check mode 8'h07, even_sel=1: good parity then bad parity.
    feed_word(64'h07, 8, 1, 1);
    chk("chk_waiting_busy", 64'(bz0), 64'(1));
    idle0();
    d0 = 0; w0 = 1;
    cyc();
    chk("chk_good_val", 64'(pv0), 64'(1));
    chk("chk_good_err", 64'(pe0), 64'(0));
    feed_word(64'h07, 8, 1, 1);
    d0 = 1; w0 = 1;
    cyc();
    chk("chk_bad_val", 64'(pv0), 64'(1));
    chk("chk_bad_err", 64'(pe0), 64'(1));
    idle0();

    // Truncated word after 5 bits, then a clean word.
    feed_word(64'hA5, 5, 1, 0);
    idle0();
    chk("trunc_ferr", 64'(fe0), 64'(1));
    chk("trunc_val", 64'(pv0), 64'(0));
    chk("trunc_cnt", 64'(wc0), 64'(5));
    idle0();
    chk("trunc_ferr_drop", 64'(fe0), 64'(0));
    feed_word(64'h3C, 8, 1, 0);
    chk("after_trunc_par", 64'(po0), 64'(1));
    idle0();

    // Asynchronous reset after 3 bits, then 8'hFF with even_sel=0.
    feed_word(64'h5A, 3, 0, 0);
    #2;
    rst_n = 0;
    w0 = 0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    feed_word(64'hFF, 8, 0, 0);
    chk("post_rst_par", 64'(po0), 64'(0));
    chk("post_rst_cnt", 64'(wc0), 64'(1));
    idle0();

    rnd0 = 1;
    repeat (2000) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_word_framer.md
Name: parity_word_framer

Overview:
- Serial parity engine, the parametrised successor to parity_bit_gen.
- Accepts an LSB-first serial bit stream qualified by wr_en and splits it into words of DATA_BITS bits.
- Generate mode: emits one registered parity result per word.
- Check mode: takes one trailing received parity bit per word, compares it with the computed value and flags mismatches.
- Also detects truncated words and keeps a running count of completed words.
- Sits between the serial data source (shift_reg style) and downstream framing/error logic.

Parameters:
- DATA_BITS, 8: bits per data word; legal range 1..64.
- CNT_W, 16: width of word_cnt.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  1  serial data bit, valid when wr_en=1.
- wr_en  input  1  bit-accept qualifier; one bit is accepted per rising edge while high.
- even_sel  input  1  parity polarity; sampled only when the first bit of a word is accepted.
- check_mode  input  1  0 = generate, 1 = check; sampled only when the first bit of a word is accepted.
- parity_out  output  1  computed parity, (^word) ^ even_sel_latched; held until the next result.
- parity_valid  output  1  one-cycle pulse marking a new parity_out.
- parity_err  output  1  one-cycle pulse, coincident with parity_valid, when the received parity bit != parity_out (check mode only).
- frame_err  output  1  one-cycle pulse when wr_en drops mid-word.
- busy  output  1  high while a word (or its parity slot) is in progress.
- word_cnt  output  CNT_W  count of completed words.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - parity_out, parity_valid, parity_err, frame_err, busy = 0; word_cnt = 0.
  - Accumulator, bit counter and latched modes cleared.
  - Reset mid-word discards the partial word; no pulses are produced.
- Every posedge: parity_valid, parity_err and frame_err default to 0.
- State IDLE:
  - wr_en=1: accept bit; acc=data_in, bit_cnt=1; latch even_sel and check_mode.
  - If DATA_BITS==1, apply the "last bit" rule immediately. Otherwise go to DATA.
- State DATA:
  - wr_en=1: acc^=data_in, bit_cnt++.
  - "Last bit" (bit_cnt reaches DATA_BITS):
    - Generate mode: parity_out=(acc^data_in)^even_l, parity_valid=1, word_cnt++, go to IDLE.
    - Check mode: store expected parity, go to PAR.
  - wr_en=0: frame_err=1, discard the word, go to IDLE; parity_out and word_cnt are unchanged.
- State PAR (check mode only):
  - Waits indefinitely for wr_en=1; an idle gap is not an error.
  - On accept: parity_out=expected, parity_valid=1, parity_err=(data_in != expected), word_cnt++, go to IDLE.
- Latency: parity_valid is registered on the edge that accepts the last data bit (generate) or the parity bit (check), so it is visible for exactly the following cycle.
- Back-to-back words: if wr_en stays high, the next edge is accepted in IDLE as bit 0 of the next word. There are no gap cycles and the next word's modes are re-latched.
- busy = (state != IDLE).
- word_cnt wraps from all-ones to 0; there is no saturation.
- even_sel or check_mode changing mid-word has no effect until the next word start.

Optional Feature:
- Macro: PARITY_STICKY_ERR_EN.
- Defined:
  - Adds input clr_err (1) and output err_sticky (1).
  - err_sticky is set on any parity_err or frame_err pulse and cleared by clr_err=1 at a posedge.
  - If set and clear occur in the same cycle, set wins.
  - Reset value 0.
- Undefined: neither port exists and there is no sticky logic.

Test Plan:
- Generate mode, DATA_BITS=8, even_sel=1, word 8'h96 LSB-first on 8 consecutive edges -> parity_out=1, parity_valid high exactly 1 cycle after the 8th edge, word_cnt=1, busy back to 0.
- Back-to-back generate, even_sel=0, words 8'h07 then 8'h00 with continuous wr_en -> two parity_valid pulses 8 cycles apart, parity_out 1 then 0, word_cnt=2, frame_err never asserted.
- Check mode, even_sel=1:
  - Word 8'h07 followed by parity bit 0 -> parity_valid=1, parity_err=0.
  - Repeat with parity bit 1 -> parity_err=1 on the same cycle as parity_valid.
  - With PARITY_STICKY_ERR_EN: err_sticky=1 until clr_err.
- Truncation: wr_en low after 5 of 8 bits -> frame_err pulse 1 cycle, no parity_valid, parity_out and word_cnt unchanged. The next full word computes correctly from a clean accumulator.
- Reset mid-word: rst_n low asynchronously (off clock edge) after 3 bits -> all outputs 0 immediately. After release, word 8'hFF with even_sel=0 -> parity_out=0, word_cnt=1.
- Wrap: CNT_W=4, 16 completed words -> word_cnt returns to 0; DATA_BITS=1 run with bits 1,0 -> parity_valid every cycle, parity_out follows data_in^even_sel.
